// File: rtl/axi_lite_gpio_master_if.sv
// AXI4-Lite channel bundle between the GPIO bus master and the GPIO slave.
// The master modport drives address/data/valid and the response readies.
interface axi_lite_gpio_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_lite_gpio_master.sv
// Single-outstanding AXI4-Lite master turning cmd/rsp transfers into
// GPIO register reads/writes; every output comes straight from a flop.
module axi_lite_gpio_master #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_areset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                timeout_err,
    axi_lite_gpio_master_if.master m
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD,
        RD_RESP,
        RSP
    } state_t;

    state_t state_q, state_d;

    logic                cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic                err_q, err_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, wait_st;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr[1:0];

    assign aw_hs  = awvalid_q && m.awready;
    assign w_hs   = wvalid_q && m.wready;
    assign b_hs   = bready_q && m.bvalid;
    assign ar_hs  = arvalid_q && m.arready;
    assign r_hs   = rready_q && m.rvalid;
    assign any_hs = aw_hs || w_hs || b_hs || ar_hs || r_hs;

    assign wait_st = (state_q == WR) || (state_q == WR_RESP) ||
                     (state_q == RD) || (state_q == RD_RESP);

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        cnt_d       = '0;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = {cmd_addr[ADDR_W-1:2], 2'b00};
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD;
                    end
                end
            end
            WR: begin
                // AW and W retire independently; leave once neither is pending
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = m.bresp;
                    state_d     = RSP;
                end
            end
            RD: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = m.rdata;
                    rsp_resp_d  = m.rresp;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // wait counter saturates at TIMEOUT; the transaction itself keeps waiting
        if (wait_st && (state_d == state_q) && !any_hs) begin
            cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);
        end
        if (wait_st && (cnt_d == TMAX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_resp    = rsp_resp_q;
    assign timeout_err = err_q;

    assign m.awaddr  = addr_q;
    assign m.awvalid = awvalid_q;
    assign m.wdata   = wdata_q;
    assign m.wstrb   = wstrb_q;
    assign m.wvalid  = wvalid_q;
    assign m.bready  = bready_q;
    assign m.araddr  = addr_q;
    assign m.arvalid = arvalid_q;
    assign m.rready  = rready_q;
endmodule

// File: tb/tb_axi_lite_gpio_master.sv
// Randomised bench for axi_lite_gpio_master: memory-backed AXI slave with
// tunable ready/response delays, checked against a word-array model.
module tb_axi_lite_gpio_master;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          timeout_err;

    axi_lite_gpio_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    axi_lite_gpio_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_write   (rsp_write),
        .rsp_rdata   (rsp_rdata),
        .rsp_resp    (rsp_resp),
        .timeout_err (timeout_err),
        .m           (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    logic [31:0] ref_mem [128];
    logic [31:0] smem    [128];

    int aw_dly, w_dly, ar_dly, b_dly, r_dly;
    logic [1:0]    sl_resp;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_wdata;
    logic [3:0]    exp_wstrb;
    logic          exp_terr;

    // AXI slave: decides readies at each falling edge, so the handshake at
    // the next rising edge is known here; memory updates on B handshake
    initial begin : slave
        int aw_n, w_n, ar_n, b_n, r_n;
        bit aw_d, w_d, ar_d, b_hs, r_hs, aw_p, w_p, ar_p;
        logic [AW-1:0] aw_a, ar_a;
        logic [31:0] wd;
        logic [3:0] ws;
        aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
        aw_d = 0; w_d = 0; ar_d = 0; b_hs = 0; r_hs = 0;
        aw_p = 0; w_p = 0; ar_p = 0;
        aw_a = '0; ar_a = '0; wd = '0; ws = '0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.bresp = 0;
        bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_n = 0; w_n = 0; ar_n = 0; b_n = 0; r_n = 0;
                aw_d = 0; w_d = 0; ar_d = 0; b_hs = 0; r_hs = 0;
                aw_p = 0; w_p = 0; ar_p = 0;
                bus.awready = 0; bus.wready = 0; bus.arready = 0;
                bus.bvalid = 0; bus.rvalid = 0;
                continue;
            end
            if (aw_p) check("aw_hold", 64'(bus.awvalid), 64'(1));
            if (w_p)  check("w_hold",  64'(bus.wvalid),  64'(1));
            if (ar_p) check("ar_hold", 64'(bus.arvalid), 64'(1));
            if (b_hs) begin
                bus.bvalid = 0; b_hs = 0;
                aw_d = 0; w_d = 0; aw_n = 0; w_n = 0; b_n = 0;
                check("bready_drop", 64'(bus.bready), 64'(0));
            end
            if (r_hs) begin
                bus.rvalid = 0; r_hs = 0;
                ar_d = 0; ar_n = 0; r_n = 0;
                check("rready_drop", 64'(bus.rready), 64'(0));
            end
            if (aw_d && w_d && !bus.bvalid) begin
                if (b_n >= b_dly) begin
                    bus.bvalid = 1; bus.bresp = sl_resp;
                end else b_n++;
            end
            if (bus.bvalid && bus.bready) begin
                b_hs = 1;
                smem[aw_a[AW-1:2]] = merge(smem[aw_a[AW-1:2]], wd, ws);
            end
            if (ar_d && !bus.rvalid) begin
                if (r_n >= r_dly) begin
                    bus.rvalid = 1; bus.rresp = sl_resp;
                    bus.rdata = smem[ar_a[AW-1:2]];
                end else r_n++;
            end
            if (bus.rvalid && bus.rready) r_hs = 1;
            if (aw_d) check("aw_drop", 64'(bus.awvalid), 64'(0));
            if (w_d)  check("w_drop",  64'(bus.wvalid),  64'(0));
            if (ar_d) check("ar_drop", 64'(bus.arvalid), 64'(0));
            bus.awready = 0; bus.wready = 0; bus.arready = 0;
            if (bus.awvalid && !aw_d) begin
                check("awaddr", 64'(bus.awaddr), 64'(exp_addr));
                if (aw_n >= aw_dly) begin
                    bus.awready = 1; aw_d = 1; aw_a = bus.awaddr;
                end else aw_n++;
            end
            if (bus.wvalid && !w_d) begin
                check("wdata", 64'({bus.wstrb, bus.wdata}),
                      64'({exp_wstrb, exp_wdata}));
                if (w_n >= w_dly) begin
                    bus.wready = 1; w_d = 1; wd = bus.wdata; ws = bus.wstrb;
                end else w_n++;
            end
            if (bus.arvalid && !ar_d) begin
                check("araddr", 64'(bus.araddr), 64'(exp_addr));
                if (ar_n >= ar_dly) begin
                    bus.arready = 1; ar_d = 1; ar_a = bus.araddr;
                end else ar_n++;
            end
            aw_p = bus.awvalid && !bus.awready;
            w_p  = bus.wvalid && !bus.wready;
            ar_p = bus.arvalid && !bus.arready;
        end
    end

    // called at a falling edge; returns at the falling edge of cycle 1
    task automatic send_cmd(input bit w, input logic [AW-1:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        exp_addr  = {a[AW-1:2], 2'b00};
        exp_wdata = d;
        exp_wstrb = s;
        cmd_valid = 1; cmd_write = w; cmd_addr = a;
        cmd_wdata = d; cmd_wstrb = s;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 0;
        check("valid_c1", 64'({bus.awvalid, bus.wvalid, bus.arvalid}),
              64'(w ? 3'b110 : 3'b001));
    endtask

    task automatic get_rsp(input bit w, input logic [31:0] ed,
                           input logic [1:0] er, input int hold,
                           input int lat, input int budget);
        int n;
        n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        if (lat >= 0) check("latency", 64'(1 + n), 64'(lat));
        for (int i = 0; i < hold; i++) begin
            check("rsp_stable", 64'({rsp_write, rsp_resp, rsp_rdata}),
                  64'({w, er, ed}));
            check("cmd_busy", 64'(cmd_ready), 64'(0));
            cmd_valid = (i == 1);
            @(negedge clk);
            check("rsp_held", 64'(rsp_valid), 64'(1));
        end
        cmd_valid = 0;
        rsp_ready = 1;
        check("rsp_fields", 64'({rsp_write, rsp_resp, rsp_rdata}),
              64'({w, er, ed}));
        @(negedge clk);
        rsp_ready = 0;
        check("rsp_drop", 64'(rsp_valid), 64'(0));
        check("cmd_back", 64'(cmd_ready), 64'(1));
        check("terr", 64'(timeout_err), 64'(exp_terr));
    endtask

    task automatic run_cmd(input bit w, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] resp, input int hold,
                           input int lat);
        logic [31:0] ed;
        ed = w ? 32'h0 : ref_mem[a[AW-1:2]];
        sl_resp = resp;
        send_cmd(w, a, d, s);
        get_rsp(w, ed, resp, hold, lat, 100);
        if (w) ref_mem[a[AW-1:2]] = merge(ref_mem[a[AW-1:2]], d, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] a;
        bit w;
        int lat;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 32'h1357_0000 + i * 32'h0001_0203;
            smem[i]    = ref_mem[i];
        end
        ref_mem[0] = 32'hA5A5_0F0F;
        smem[0]    = 32'hA5A5_0F0F;
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;
        sl_resp = 0; exp_addr = 0; exp_wdata = 0; exp_wstrb = 0;
        exp_terr = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0;
        cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        rst = 1;
        repeat (3) @(negedge clk);
        check("rst_ctl", 64'({cmd_ready, rsp_valid, timeout_err,
              bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
              bus.rready}), 64'(0));
        rst = 0;
        @(negedge clk);
        check("cmd_ready_up", 64'(cmd_ready), 64'(1));

        run_cmd(1, 9'h004, 32'h0000_00FF, 4'hF, 2'b00, 0, 3);
        run_cmd(0, 9'h003, 32'h0, 4'h0, 2'b00, 0, 3);
        run_cmd(0, 9'h004, 32'h0, 4'h0, 2'b00, 0, 3);

        aw_dly = 3; w_dly = 0;
        run_cmd(1, 9'h010, 32'hCAFE_F00D, 4'b0101, 2'b00, 0, -1);
        aw_dly = 0;
        run_cmd(0, 9'h010, 32'h0, 4'h0, 2'b00, 0, 3);

        run_cmd(0, 9'h08C, 32'h0, 4'h0, 2'b10, 5, 3);

        for (int t = 0; t < 40; t++) begin
            aw_dly = $urandom_range(0, 4);
            w_dly  = $urandom_range(0, 4);
            ar_dly = $urandom_range(0, 4);
            b_dly  = $urandom_range(0, 4);
            r_dly  = $urandom_range(0, 4);
            w = 1'($urandom_range(0, 1));
            a = AW'($urandom);
            lat = (aw_dly + w_dly + ar_dly + b_dly + r_dly == 0) ? 3 : -1;
            run_cmd(w, a, $urandom, 4'($urandom), 2'($urandom),
                    $urandom_range(0, 3), lat);
        end
        aw_dly = 0; w_dly = 0; ar_dly = 0; b_dly = 0; r_dly = 0;

        ar_dly = 100000;
        sl_resp = 2'b00;
        send_cmd(0, 9'h020, 32'h0, 4'h0);
        repeat (14) @(negedge clk);
        check("to_early", 64'({timeout_err, bus.arvalid}), 64'(2'b01));
        repeat (3) @(negedge clk);
        check("to_set", 64'({timeout_err, bus.arvalid}), 64'(2'b11));
        exp_terr = 1;
        ar_dly = 0;
        get_rsp(0, ref_mem[8], 2'b00, 0, -1, 50);

        b_dly = 20;
        sl_resp = 2'b00;
        send_cmd(1, 9'h030, 32'h1234_5678, 4'hF);
        for (int n = 0; n < 20 && !bus.bready; n++) @(negedge clk);
        check("in_wr_resp", 64'(bus.bready), 64'(1));
        #2 rst = 1;
        #1;
        check("arst_ctl", 64'({cmd_ready, rsp_valid, rsp_write, rsp_resp,
              timeout_err, bus.awvalid, bus.wvalid, bus.bready,
              bus.arvalid, bus.rready}), 64'(0));
        check("arst_data", 64'({rsp_rdata, bus.awaddr}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        exp_terr = 0;
        b_dly = 0;
        @(negedge clk);
        run_cmd(0, 9'h030, 32'h0, 4'h0, 2'b00, 0, 3);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/axi_lite_gpio_master.md
Name: axi_lite_gpio_master

Overview:
- Single-outstanding AXI4-Lite master that converts simple command/response transfers into AXI4-Lite read/write transactions on the GPIO slave port.
- Sits directly upstream of the AXI GPIO slave and drives every s_axi_* slave input.
- Used by the test harness and by on-chip control logic to access GPIO registers (DATA, TRI, GIER, IER, ISR) at word-aligned offsets within a 512-byte window.

Parameters:
- ADDR_W, 9, AXI address width (byte address).
- DATA_W, 32, AXI data width; strobe width is DATA_W/8.
- TIMEOUT, 1024, cycles a channel may wait for a handshake before timeout_err sets; must be ≥2.

Ports:
- s_axi_aclk  in  1  clock; all logic is rising-edge.
- s_axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP as returned by the slave.
- timeout_err  out  1  sticky; set on any channel timeout.
- m_awaddr  out  ADDR_W;  m_awvalid  out  1;  m_awready  in  1.
- m_wdata  out  DATA_W;  m_wstrb  out  DATA_W/8;  m_wvalid  out  1;  m_wready  in  1.
- m_bresp  in  2;  m_bvalid  in  1;  m_bready  out  1.
- m_araddr  out  ADDR_W;  m_arvalid  out  1;  m_arready  in  1.
- m_rdata  in  DATA_W;  m_rresp  in  2;  m_rvalid  in  1;  m_rready  out  1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0 and state is IDLE.
  - cmd_ready rises on the first clock edge after reset deasserts.
- Every output is registered. No combinational path from any input to any output.
- FSM states: IDLE, WR, WR_RESP, RD, RD_RESP, RSP.
- IDLE:
  - cmd_ready=1.
  - On a command handshake, latch the command, drop cmd_ready, and go to WR or RD.
  - Address is driven as {cmd_addr[ADDR_W-1:2], 2'b00}.
- WR:
  - m_awvalid and m_wvalid assert together one cycle after acceptance.
  - Each valid drops independently on its own handshake (awvalid&&awready, wvalid&&wready). AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP only after both have completed.
  - Address, data and strobe are stable while the corresponding valid is high.
- WR_RESP:
  - m_bready=1.
  - On m_bvalid, capture m_bresp, drop m_bready, and go to RSP with rsp_write=1 and rsp_rdata=0.
- RD:
  - m_arvalid=1 until m_arready, then go to RD_RESP.
- RD_RESP:
  - m_rready=1.
  - On m_rvalid, capture m_rdata and m_rresp, drop m_rready, and go to RSP with rsp_write=0.
- RSP:
  - rsp_valid=1 with stable fields until rsp_ready, then go to IDLE.
  - cmd_ready reasserts in the cycle after the response handshake, so back-to-back commands are separated by at least one idle cycle.
- Minimum latency (slave always ready, bvalid/rvalid one cycle after address):
  - Write: command handshake at cycle 0, awvalid/wvalid at 1, bvalid at 2, rsp_valid at 3.
  - Read: same timing.
- Valid signals are never withdrawn before their handshake (AXI rule), including after a timeout.
- Timeout:
  - A wait counter resets on every state change and on every channel handshake.
  - When it reaches TIMEOUT in WR, WR_RESP, RD or RD_RESP, timeout_err sets.
  - The transaction keeps waiting.
  - timeout_err clears only on reset.
- Error responses (SLVERR=2'b10, DECERR=2'b11) are passed through unchanged and are not errors of this block.
- Response signals arriving outside their wait state are ignored; bready/rready are 0 there.
- Reset mid-transaction: all valids/readys drop immediately; the in-flight command and response are discarded.

Test Plan:
- Write cmd_addr=0x004, cmd_wdata=0x0000_00FF, cmd_wstrb=0xF, slave always ready, bresp=00 -> m_awaddr=0x004 with awvalid/wvalid at cycle 1; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read cmd_addr=0x003, slave returns rdata=0xA5A5_0F0F, rresp=00 -> m_araddr=0x000; rsp_rdata=0xA5A5_0F0F, rsp_write=0.
- Write with m_wready asserted 3 cycles before m_awready -> wvalid drops after its handshake, awvalid held until its handshake; exactly one bready phase and one response.
- Slave never asserts m_arready with TIMEOUT=16 -> timeout_err=1 at wait count 16; arvalid stays 1; asserting arready later completes the read normally.
- rsp_ready held low 5 cycles, then cmd_valid pulsed -> response fields stable, cmd_ready=0 throughout, new command accepted only after the response handshake; rresp=10 is reported unchanged.
- Assert s_axi_areset during WR_RESP -> all outputs 0 asynchronously; after release a fresh read completes correctly.
